// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with per-register pending-write scoreboard
// Optional REGFILE_BYPASS_EN forwards the same-cycle write to matching read ports.
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  output logic [AW:0]          busy_cnt
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic             wrHit;
  logic             setHit;
  logic             cntInc;
  logic             cntDec;

  assign wrHit  = wr_en && (wr_addr != '0);
  assign setHit = sb_set && (sb_addr != '0);

  // Set is applied after clear so a same-register collision leaves the bit busy.
  always_comb begin
    busyNext = busy;
    if (wrHit) busyNext[wr_addr] = 1'b0;
    if (setHit) busyNext[sb_addr] = 1'b1;
  end

  assign cntInc = setHit && !busy[sb_addr];
  assign cntDec = wrHit && busy[wr_addr] && !(setHit && (sb_addr == wr_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wrHit) regs[wr_addr] <= wr_data;
      busy     <= busyNext;
      busy_cnt <= busy_cnt + (AW+1)'(cntInc) - (AW+1)'(cntDec);
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    rAddr;
    logic [WIDTH-1:0] rData;
    logic             rBusy;

    assign rAddr = rd_addr[p*AW +: AW];

    always_comb begin
      rData = regs[rAddr];
      rBusy = busy[rAddr];
`ifdef REGFILE_BYPASS_EN
      if (wrHit && (wr_addr == rAddr)) begin
        rData = wr_data;
        rBusy = setHit && (sb_addr == rAddr);
      end
`endif
    end

    assign rd_data[p*WIDTH +: WIDTH] = rData;
    assign rd_busy[p]                = rBusy;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with a per-register scoreboard, successor to the fixed 32x32 two-read-port file in the datapath. It provides NRD combinational read ports, one clocked write port, a hardwired zero register, asynchronous clear, and pending-write (busy) tracking. The issue stage uses busy tracking to stall on RAW hazards. It sits between decode/issue (reads, scoreboard set) and writeback (write, scoreboard clear).

## Interface
- `WIDTH`, 32: data width in bits.
- `DEPTH`, 32: number of registers; a power of two, at least 2.
- `NRD`, 2: number of read ports, at least 1.
- `AW`, `$clog2(DEPTH)`: address width (derived; not overridden).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_addr` in NRD*AW: read addresses; port i occupies bits [i*AW +: AW].
- `rd_data` out NRD*WIDTH: read data; port i occupies bits [i*WIDTH +: WIDTH].
- `rd_busy` out NRD: port i's register has a write pending.
- `wr_en` in 1: write strobe.
- `wr_addr` in AW: write address.
- `wr_data` in WIDTH: write data.
- `sb_set` in 1: mark `sb_addr` as pending (an instruction was issued that targets it).
- `sb_addr` in AW: destination register being reserved.
- `busy_cnt` out AW+1: number of registers currently marked busy.

## Operation
- Storage: DEPTH x WIDTH array plus a DEPTH-bit busy vector.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to it are ignored; `sb_set` targeting it is ignored.
- Read: `rd_data[i]` = `REG[rd_addr[i]]`, combinational. `rd_busy[i]` = `busy[rd_addr[i]]`.
- Write: on the rising edge with `wr_en` and `wr_addr` != 0, `REG[wr_addr]` <= `wr_data` and `busy[wr_addr]` <= 0.
- Scoreboard set: on the rising edge with `sb_set` and `sb_addr` != 0, `busy[sb_addr]` <= 1.
- Same-cycle set and clear on the same register: set wins (the busy bit ends at 1; the data write still occurs). Set and clear on different registers both take effect.
- Set on a register that is already busy: no change; `busy_cnt` is not incremented.
- Write to a register that is not busy: data is written; `busy_cnt` is unchanged.
- `busy_cnt`: registered counter equal to the population count of the busy vector.
  - Per-cycle delta = (+1 if the set targets a non-busy register and is effective) − (1 if the clear targets a busy register and is not overridden by a set to the same register).
  - Range 0..DEPTH−1; it can never wrap.
- Reset: while `rst_n` is low, all registers are 0, all busy bits are 0, and `busy_cnt` is 0. Reset asserted mid-operation clears state immediately, without waiting for a clock edge; a pending write in that cycle is lost.
- Reset values of the outputs: `rd_data` all 0, `rd_busy` all 0, `busy_cnt` 0.

## Timing
- Read latency 0: combinational from `rd_addr` and the state.
- Write and scoreboard latency: 1 edge; the effect is visible after the edge.
- Without bypass, a read of `wr_addr` in the same cycle as the write returns the old value and busy = 1 (if it was set).
- `busy_cnt` updates on the same edge as the busy vector.
- No handshake back-pressure: every `wr_en` and `sb_set` is accepted in its cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding for each port. When `wr_en` is high, `wr_addr` == `rd_addr[i]`, and `wr_addr` != 0:
  - `rd_data[i]` = `wr_data` in the same cycle.
  - `rd_busy[i]` = 0, unless `sb_set` targets the same register in that cycle, in which case `rd_busy[i]` = 1.
- `REGFILE_BYPASS_EN` undefined: no forwarding; reads reflect registered state only.

## Test plan
- Reset: drive `rst_n` low mid-run after writing `REG[5]`=0xDEADBEEF and setting `busy[5]` -> `rd_data` reads 0 immediately, `rd_busy` = 0, `busy_cnt` = 0, with no clock edge needed.
- Register zero: `wr_en`=1, `wr_addr`=0, `wr_data`=0xFFFFFFFF, plus `sb_set` on 0 -> reading addr 0 gives 0, `rd_busy` = 0, `busy_cnt` = 0.
- Scoreboard: set r3, then set r7 -> `busy_cnt` = 2. Write r3 = 0x12345678 -> `busy_cnt` = 1, reading r3 gives 0x12345678 with busy 0, r7 is still busy.
- Simultaneous events: with r9 busy, same cycle `wr_en` r9 = 0xA5A5A5A5 and `sb_set` r9 -> r9 = 0xA5A5A5A5, still busy, `busy_cnt` unchanged. Separately, set r4 while clearing busy r6 -> `busy_cnt` unchanged.
- Bypass: write r10 = 0xCAFEF00D while both ports read r10.
  - With `REGFILE_BYPASS_EN`: both ports return 0xCAFEF00D in the same cycle, busy 0.
  - Without it: old value 0 until after the edge.
- Capacity: set all r1..r31 (DEPTH=32) -> `busy_cnt` = 31. Re-setting r1 leaves it at 31; writing all 31 registers back returns it to 0.
